pc_sequencer: RTL
=================

# pc_sequencer

Control FSM that sequences the program counter and its input mux for the RAT MCU core. Each instruction takes a FETCH cycle (PC increments) and an EXEC cycle. In EXEC the block resolves branch, call and return opcodes against the C/Z flags and drives the PC load and mux select. It also latches and services external interrupts by vectoring the PC to the ISR address 0x3FF and pushing the return address on the stack.

## Interface
- No parameters; all encodings come from `pc_seq_pkg`.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `OPCODE` in 7: `{IR[17:13], IR[1:0]}` of the instruction currently held in the IR.
- `C_FLAG` in 1: carry flag.
- `Z_FLAG` in 1: zero flag.
- `INT` in 1: interrupt request, level or single-cycle pulse.
- `PC_RST` out 1: clears the program counter.
- `PC_LD` out 1: loads the program counter from the mux.
- `PC_INC` out 1: increments the program counter.
- `PC_MUX_SEL` out 2: 0 selects IR[9:0], 1 selects DATA_OUT (stack), 2 selects 0x3FF, 3 is reserved and never driven.
- `SP_INCR` out 1: stack-pointer increment (pop).
- `SP_DECR` out 1: stack-pointer decrement (push).
- `SCR_WE` out 1: scratch RAM write.
- `SCR_DATA_SEL` out 1: 1 selects the PC as scratch write data.
- `I_FLAG` out 1: interrupt-enable flag (register).

## Operation
- States: `ST_INIT`, `ST_FETCH`, `ST_EXEC`, `ST_INTR`.
- Transitions:
  - INIT→FETCH
  - FETCH→EXEC
  - EXEC→INTR if `int_pend & I_FLAG`, otherwise EXEC→FETCH
  - INTR→FETCH
- INIT: `PC_RST`=1; everything else 0.
- FETCH: `PC_INC`=1 only.
- EXEC decode (all other opcodes drive no PC or stack outputs):
  - BRN: `PC_LD`=1, sel 0.
  - BREQ taken when Z=1; BRNE when Z=0; BRCS when C=1; BRCC when C=0. Taken → `PC_LD`=1, sel 0. Not taken → no PC output.
  - CALL: `PC_LD`, sel 0, `SCR_WE`, `SCR_DATA_SEL`=1, `SP_DECR`.
  - RET: `PC_LD`, sel 1, `SP_INCR`.
  - RETIE: as RET, and sets `I_FLAG`.
  - RETID: as RET, and clears `I_FLAG`.
  - SEI: sets `I_FLAG`. CLI: clears `I_FLAG`.
- INTR: `PC_LD`, sel 2, `SCR_WE`, `SCR_DATA_SEL`=1, `SP_DECR`; clears `I_FLAG` and `int_pend`.
- `int_pend` sets on any cycle with `INT`=1 and holds until INTR. It is latched even while `I_FLAG`=0 and is serviced after a later SEI or RETIE.
- `PC_MUX_SEL` is 0 whenever `PC_LD`=0.
- At most one of `PC_RST`, `PC_LD`, `PC_INC` is high in any cycle.
- At most one of `SP_INCR`, `SP_DECR` is high in any cycle.

## Timing
- Reset: an edge with `RST`=0 forces state INIT and clears `I_FLAG` and `int_pend`.
  - The cycle after that edge shows `PC_RST`=1 and all other outputs 0.
  - Reset overrides any state, including mid-INTR.
- All outputs are combinational from state, `OPCODE` and the flags. `I_FLAG`, `int_pend` and state are registered.
- Instruction latency is 2 cycles; interrupt entry adds 1 cycle after the EXEC in which it is detected.
- An `INT` arriving in the same cycle as EXEC is latched at that edge and serviced after the next instruction, not the current one.
- SEI/RETIE in EXEC with `int_pend` already set: the `I_FLAG` update lands at the same edge, so the interrupt is taken after the following instruction's EXEC.
- CLI in EXEC with `int_pend` and `I_FLAG`=1 set: the EXEC→INTR decision uses the pre-edge `I_FLAG`, so the interrupt is taken.
- `INT` during INTR: it is re-latched (a set on the same edge wins over the clear) and serviced after the next RETIE.

## Structure
- `pc_seq_pkg` holds:
  - the state enum;
  - the `PC_MUX_SEL` constants `MUX_IR`=0, `MUX_STK`=1, `MUX_ISR`=2;
  - the 7-bit opcode constants: BRN=0010000, CALL=0010001, BREQ=0010010, BRNE=0010011, BRCS=0010100, BRCC=0010101, RET=0110010, SEI=0110100, CLI=0110101, RETID=0110110, RETIE=0110111.
- One sub-module, `branch_cond`: combinational, (`OPCODE`, `C_FLAG`, `Z_FLAG`) → `is_branch`, `taken`.
- FSM, `I_FLAG` and `int_pend` live in `pc_sequencer`.

## Test plan
- Reset: `RST`=0 for one edge from EXEC → next cycle `PC_RST`=1; then FETCH `PC_INC`=1, then EXEC; `I_FLAG`=0.
- Conditional branch: BREQ with Z=1 in EXEC → `PC_LD`=1, sel 0. Same with Z=0 → `PC_LD`=0. BRCC with C=0 → `PC_LD`=1.
- CALL then RET:
  - CALL EXEC → `PC_LD`, sel 0, `SCR_WE`, `SCR_DATA_SEL`=1, `SP_DECR`.
  - RET EXEC → `PC_LD`, sel 1, `SP_INCR`; `SP_DECR`=0.
- Interrupt service:
  - SEI, then a 1-cycle `INT` pulse during FETCH.
  - EXEC → INTR with `PC_LD`, sel 2, `SCR_WE`, `SP_DECR`; `I_FLAG`→0; next state FETCH.
- Masked interrupt: `INT` pulse with `I_FLAG`=0 → no INTR over 3 instructions. RETIE → INTR follows the next instruction's EXEC; `int_pend` cleared.
- Reset during INTR: `RST`=0 → INIT next; `int_pend`=0; no stray `SCR_WE`.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the RAT MCU program-counter sequencer: FSM states, PC mux selects, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [1:0] MUX_IR  = 2'd0;
    localparam logic [1:0] MUX_STK = 2'd1;
    localparam logic [1:0] MUX_ISR = 2'd2;

    // Opcode is {IR[17:13], IR[1:0]}
    localparam logic [6:0] OP_BRN   = 7'b0010000;
    localparam logic [6:0] OP_CALL  = 7'b0010001;
    localparam logic [6:0] OP_BREQ  = 7'b0010010;
    localparam logic [6:0] OP_BRNE  = 7'b0010011;
    localparam logic [6:0] OP_BRCS  = 7'b0010100;
    localparam logic [6:0] OP_BRCC  = 7'b0010101;
    localparam logic [6:0] OP_RET   = 7'b0110010;
    localparam logic [6:0] OP_SEI   = 7'b0110100;
    localparam logic [6:0] OP_CLI   = 7'b0110101;
    localparam logic [6:0] OP_RETID = 7'b0110110;
    localparam logic [6:0] OP_RETIE = 7'b0110111;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Branch decode: flags a branch opcode and whether its C/Z condition holds.
// Latency: combinational.
// Backpressure: none.
module branch_cond
    import pc_seq_pkg::*;
(
    input  logic [6:0] OPCODE,
    input  logic       C_FLAG,
    input  logic       Z_FLAG,
    output logic       is_branch,
    output logic       taken
);

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (OPCODE)
            OP_BRN:  taken = 1'b1;
            OP_BREQ: taken = Z_FLAG;
            OP_BRNE: taken = ~Z_FLAG;
            OP_BRCS: taken = C_FLAG;
            OP_BRCC: taken = ~C_FLAG;
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/exec sequencer driving PC load/inc/reset, PC mux, stack pointer and scratch writes; services interrupts.
// Latency: 2 cycles per instruction, +1 cycle for interrupt entry after the detecting EXEC.
// Backpressure: none; INT is latched into int_pend until the INTR state consumes it.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic       C_FLAG,
    input  logic       Z_FLAG,
    input  logic       INT,
    output logic       PC_RST,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       SCR_WE,
    output logic       SCR_DATA_SEL,
    output logic       I_FLAG
);

    state_t state;
    logic   int_pend;
    logic   is_branch;
    logic   taken;

    branch_cond u_branch_cond (
        .OPCODE    (OPCODE),
        .C_FLAG    (C_FLAG),
        .Z_FLAG    (Z_FLAG),
        .is_branch (is_branch),
        .taken     (taken)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_INIT;
            I_FLAG   <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            // A request arriving during INTR must survive the clear.
            if (INT)
                int_pend <= 1'b1;
            else if (state == ST_INTR)
                int_pend <= 1'b0;

            case (state)
                ST_INIT:  state <= ST_FETCH;
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    state <= (int_pend && I_FLAG) ? ST_INTR : ST_FETCH;
                    case (OPCODE)
                        OP_SEI, OP_RETIE: I_FLAG <= 1'b1;
                        OP_CLI, OP_RETID: I_FLAG <= 1'b0;
                        default:          ;
                    endcase
                end
                ST_INTR: begin
                    state  <= ST_FETCH;
                    I_FLAG <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        PC_RST       = 1'b0;
        PC_LD        = 1'b0;
        PC_INC       = 1'b0;
        PC_MUX_SEL   = MUX_IR;
        SP_INCR      = 1'b0;
        SP_DECR      = 1'b0;
        SCR_WE       = 1'b0;
        SCR_DATA_SEL = 1'b0;
        case (state)
            ST_INIT:  PC_RST = 1'b1;
            ST_FETCH: PC_INC = 1'b1;
            ST_EXEC: begin
                if (is_branch) begin
                    PC_LD = taken;
                end else begin
                    case (OPCODE)
                        OP_CALL: begin
                            PC_LD        = 1'b1;
                            SCR_WE       = 1'b1;
                            SCR_DATA_SEL = 1'b1;
                            SP_DECR      = 1'b1;
                        end
                        OP_RET, OP_RETIE, OP_RETID: begin
                            PC_LD      = 1'b1;
                            PC_MUX_SEL = MUX_STK;
                            SP_INCR    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_INTR: begin
                PC_LD        = 1'b1;
                PC_MUX_SEL   = MUX_ISR;
                SCR_WE       = 1'b1;
                SCR_DATA_SEL = 1'b1;
                SP_DECR      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
